// File: rtl/muldiv_seq.sv
// Sequential unsigned multiply/divide (multu/divu) for the EX stage.
// Each of 32 iterations borrows the shared 32-bit ALU through alu_a/alu_b/alu_ctr and consumes alu_res.
//
//   state  | meaning
//   IDLE   | waiting for start; ALU operand mux released
//   RUN    | iterating; owns the ALU, stalls the pipeline
//   DONE   | one-cycle completion pulse, hi/lo valid

module muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        kill,
  input  logic [31:0] alu_res,
  output logic        alu_own,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctr,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] shf_q, shf_d;
  logic [31:0] opnd_q, opnd_d;
  logic        mode_q, mode_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] acc_nx, shf_nx;
  logic        ma, mb, mr, add_c, sub_nb;

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_ctr = '0;
    if (state_q == S_RUN) begin
      if (!mode_q) begin
        alu_a   = acc_q;
        alu_b   = shf_q[0] ? opnd_q : '0;
        alu_ctr = ALU_ADD;
      end else begin
        alu_a   = {acc_q[30:0], shf_q[31]};
        alu_b   = opnd_q;
        alu_ctr = ALU_SUB;
      end
    end
  end

  // The ALU has no carry-out, so rebuild it from the operand/result MSBs.
  assign ma     = alu_a[31];
  assign mb     = alu_b[31];
  assign mr     = alu_res[31];
  assign add_c  = (ma & mb) | ((ma | mb) & ~mr);
  assign sub_nb = (ma & ~mb) | ((ma | ~mb) & ~mr);

  always_comb begin
    acc_nx = acc_q;
    shf_nx = shf_q;
    if (!mode_q) begin
      {acc_nx, shf_nx} = {add_c, alu_res, shf_q[31:1]};
    end else if (acc_q[31] | sub_nb) begin
      acc_nx = alu_res;
      shf_nx = {shf_q[30:0], 1'b1};
    end else begin
      acc_nx = alu_a;
      shf_nx = {shf_q[30:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    shf_d   = shf_q;
    opnd_d  = opnd_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start && !kill) begin
          state_d = S_RUN;
          mode_d  = op;
          opnd_d  = src_b;
          cnt_d   = '0;
          acc_d   = '0;
          shf_d   = src_a;
        end
      end
      S_RUN: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_nx;
          shf_d = shf_nx;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = S_DONE;
            hi_d    = acc_nx;
            lo_d    = shf_nx;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      shf_q   <= '0;
      opnd_q  <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      shf_q   <= shf_d;
      opnd_q  <= opnd_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign alu_own = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed spec cases plus random multu/divu against a
// 64-bit arithmetic reference, with a behavioural model of the shared ALU.

module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, op, kill;
  logic [31:0] src_a, src_b, alu_res;
  logic        alu_own, busy, done;
  logic [31:0] alu_a, alu_b, hi, lo;
  logic [2:0]  alu_ctr;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cyc_a, done_cyc_b;

  muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .kill(kill), .alu_res(alu_res),
    .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Shared EX-stage ALU: 110 subtracts, anything else adds.
  always_comb alu_res = (alu_ctr == 3'b110) ? (alu_a - alu_b) : (alu_a + alu_b);

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (!o) begin
      p = {32'd0, a} * {32'd0, b};
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  // Starts an operation, runs it to the done cycle and checks it; mid >= 0 pulses
  // a bogus start on that RUN cycle. Returns with the DUT in its DONE cycle.
  task automatic run_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int mid);
    int busy_n, bad_ctr, early_done;
    logic [2:0] want_ctr;
    want_ctr = o ? 3'b110 : 3'b010;
    start = 1'b1; op = o; src_a = a; src_b = b;
    tick();
    start = 1'b0;
    busy_n = 0; bad_ctr = 0; early_done = 0;
    for (int i = 0; i < 32; i++) begin
      if (busy && alu_own) busy_n++;
      if (alu_ctr !== want_ctr) bad_ctr++;
      if (done) early_done++;
      if (i == mid) begin
        start = 1'b1; op = ~o; src_a = $urandom; src_b = $urandom;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check({tag, " busy cycles"}, 64'(busy_n), 64'd32);
    check({tag, " alu_ctr bad cycles"}, 64'(bad_ctr), 64'd0);
    check({tag, " early done"}, 64'(early_done), 64'd0);
    check({tag, " done"}, {63'd0, done}, 64'd1);
    check({tag, " hi:lo"}, {hi, lo}, exp);
  endtask

  // Starts 100/7 and interrupts it on RUN cycle 10 with kill (use_rst=0) or reset.
  task automatic abort_op(input logic use_rst);
    start = 1'b1; op = 1'b1; src_a = 32'd100; src_b = 32'd7;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    if (use_rst) rst_n = 1'b0; else kill = 1'b1;
    tick();
    rst_n = 1'b1; kill = 1'b0;
  endtask

  initial begin
    int late_done;
    logic        r_op;
    logic [31:0] r_a, r_b;

    rst_n = 1'b0; start = 1'b0; op = 1'b0; kill = 1'b0; src_a = '0; src_b = '0;
    tick(); tick();
    rst_n = 1'b1;
    check("reset busy/own/done", {61'd0, busy, alu_own, done}, 64'd0);
    check("reset hi:lo", {hi, lo}, 64'd0);
    check("idle alu_a:alu_b", {alu_a, alu_b}, 64'd0);
    check("idle alu_ctr", {61'd0, alu_ctr}, 64'd0);

    run_op("mul 7x6", 1'b0, 32'd7, 32'd6, 64'd42, -1);
    tick();
    check("idle after done", {62'd0, busy, done}, 64'd0);
    check("hi:lo held", {hi, lo}, 64'd42);

    run_op("mul carry", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1);
    tick();
    run_op("div 100/7", 1'b1, 32'd100, 32'd7, {32'd2, 32'd14}, -1);
    tick();
    run_op("div big", 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, {32'h7FFF_FFFE, 32'd1}, -1);
    tick();
    run_op("div by zero", 1'b1, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, -1);
    tick();

    run_op("mul 7x6 pre-kill", 1'b0, 32'd7, 32'd6, 64'd42, -1);
    tick();
    abort_op(1'b0);
    check("kill busy/own/done", {61'd0, busy, alu_own, done}, 64'd0);
    check("kill hi:lo kept", {hi, lo}, 64'd42);
    late_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) late_done++;
      tick();
    end
    check("no done after kill", 64'(late_done), 64'd0);

    abort_op(1'b1);
    check("rst busy/own/done", {61'd0, busy, alu_own, done}, 64'd0);
    check("rst hi:lo", {hi, lo}, 64'd0);
    check("rst alu_a:alu_b", {alu_a, alu_b}, 64'd0);
    check("rst alu_ctr", {61'd0, alu_ctr}, 64'd0);

    start = 1'b1; kill = 1'b1; op = 1'b0; src_a = 32'd3; src_b = 32'd3;
    tick();
    start = 1'b0; kill = 1'b0;
    check("kill beats start", {62'd0, busy, done}, 64'd0);

    run_op("mid-run start", 1'b1, 32'd100, 32'd7, {32'd2, 32'd14}, 12);
    tick();

    run_op("b2b first 7x6", 1'b0, 32'd7, 32'd6, 64'd42, -1);
    done_cyc_a = cyc;
    run_op("b2b second 100/7", 1'b1, 32'd100, 32'd7, {32'd2, 32'd14}, -1);
    done_cyc_b = cyc;
    check("b2b done spacing", 64'(done_cyc_b - done_cyc_a), 64'd33);
    tick();

    for (int n = 0; n < 24; n++) begin
      r_op = 1'($urandom);
      r_a  = $urandom;
      case (n % 4)
        0: r_b = $urandom;
        1: r_b = $urandom_range(1, 255);
        2: r_b = 32'd0;
        default: r_b = 32'h8000_0000 | $urandom;
      endcase
      run_op($sformatf("rand%0d", n), r_op, r_a, r_b, ref_result(r_op, r_a, r_b), -1);
      if (n % 3 != 0) tick();
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
